nibble_word_loader: RTL and testbench
=====================================

NIBBLE_WORD_LOADER -- requirements
Module: nibble_word_loader

Interface
REQ-001 SHALL have parameter NUM_NIBBLES, default 4, meaning nibbles per assembled word; legal range 1..7.
REQ-002 SHALL have parameter ENTRY_TIMEOUT, default 250_000_000, meaning idle clock cycles before a partial entry is discarded; 0 disables the timeout.
REQ-003 SHALL have port Clock  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port KeyLoad  input  1  one-cycle filtered key pulse; appends Nibble.
REQ-006 SHALL have port KeyClear  input  1  one-cycle filtered key pulse; aborts the entry.
REQ-007 SHALL have port Nibble  input  4  switch value sampled on a KeyLoad cycle.
REQ-008 SHALL have port Word  output  4*NUM_NIBBLES  assembled word, live during entry.
REQ-009 SHALL have port Digits  output  3  count of nibbles entered so far.
REQ-010 SHALL have port Valid  output  1  Word complete and offered downstream.
REQ-011 SHALL have port Ready  input  1  downstream accepts Word when high with Valid.

Function
REQ-012 SHALL implement two states: COLLECT (Valid=0) and HOLD (Valid=1).
REQ-013 SHALL register all outputs; no output depends combinationally on any input.
REQ-014 COLLECT, KeyLoad=1, KeyClear=0: next Word = {Word shifted left 4, Nibble}, upper bits discarded; Digits increments.
REQ-015 COLLECT, KeyLoad while Digits = NUM_NIBBLES-1: Word takes the final nibble, Digits becomes NUM_NIBBLES, state goes to HOLD, Valid=1 on the same edge (1-cycle latency from the pulse).
REQ-016 HOLD: KeyLoad SHALL be ignored; Word, Digits and Valid held stable until a handshake or abort.
REQ-017 HOLD, Valid=1 and Ready=1 at an edge: transfer completes; next Valid=0, Word=0, Digits=0, state COLLECT.
REQ-018 Ready while in COLLECT SHALL have no effect.
REQ-019 KeyClear=1 in any state: next Word=0, Digits=0, Valid=0, state COLLECT, timer cleared.
REQ-020 KeyClear and KeyLoad in the same cycle: clear SHALL win; Nibble discarded.
REQ-021 KeyClear and Ready in the same HOLD cycle: the transfer counts as completed; resulting state is as in REQ-017.
REQ-022 Idle timer: in COLLECT with Digits>0, counts cycles since the last accepted KeyLoad; reloads to 0 on each accepted KeyLoad; held at 0 when Digits=0 or in HOLD.
REQ-023 When ENTRY_TIMEOUT>0 and the timer reaches ENTRY_TIMEOUT-1 with no KeyLoad that cycle: next Word=0, Digits=0 (silent discard, Valid stays 0).
REQ-024 A KeyLoad in the timeout cycle SHALL be accepted and SHALL restart the timer; the discard does not occur.
REQ-025 Timer width SHALL hold ENTRY_TIMEOUT without wrap; it SHALL saturate, never roll over.
REQ-026 KeyLoad pulses longer than one cycle SHALL each be treated as separate presses (upstream guarantees single-cycle pulses).

Reset
REQ-027 Reset=1 at an edge: Word=0, Digits=0, Valid=0, state COLLECT, timer=0, regardless of any other input.
REQ-028 Reset SHALL override KeyLoad, KeyClear, Ready and timeout in the same cycle, including mid-entry and in HOLD.
REQ-029 Power-up initial values SHALL match reset values.

Verification (NUM_NIBBLES=4, ENTRY_TIMEOUT=10 on the bench)
REQ-030 Load 0x1,0x2,0x3,0x4 with Ready=0 -> Word=0x1234, Digits=4, Valid=1 one cycle after the fourth pulse, held 20 cycles; Ready=1 -> next cycle Valid=0, Word=0, Digits=0.
REQ-031 Load 0xA,0xB; KeyClear with KeyLoad(0xC) in the same cycle -> Word=0, Digits=0, Valid=0; next load 0x5 -> Word=0x0005, Digits=1.
REQ-032 In HOLD with Word=0xBEEF, pulse KeyLoad(0x7) -> Word stays 0xBEEF, Digits=4, Valid=1.
REQ-033 Load 0x9, idle 10 cycles -> Word=0, Digits=0, Valid=0; repeat with KeyLoad(0x8) at the 10th idle cycle -> Word=0x0098, Digits=2.
REQ-034 Load 0x1,0x2,0x3,0x4, Reset=1 with Ready=1 in the same cycle -> Word=0, Digits=0, Valid=0, no transfer counted by the scoreboard.
REQ-035 Randomised KeyLoad/KeyClear/Ready traffic -> scoreboard model matches Word, Digits and Valid every cycle; Word never changes while Valid=1.

Source files
------------

// File: rtl/nibble_word_loader.sv
// Keypad nibble entry: shifts nibbles into a word and offers the completed word
// with a valid/ready handshake. A partial entry is silently discarded after an idle timeout.
module nibble_word_loader #(
  parameter int unsigned NUM_NIBBLES   = 4,
  parameter int unsigned ENTRY_TIMEOUT = 250_000_000
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     KeyLoad,
  input  logic                     KeyClear,
  input  logic [3:0]               Nibble,
  output logic [4*NUM_NIBBLES-1:0] Word,
  output logic [2:0]               Digits,
  output logic                     Valid,
  input  logic                     Ready
);
  localparam int unsigned WW = 4 * NUM_NIBBLES;
  localparam int unsigned TW = (ENTRY_TIMEOUT > 0) ? $clog2(ENTRY_TIMEOUT + 1) : 1;
  localparam bit TIMEOUT_EN = (ENTRY_TIMEOUT > 0);
  localparam logic [TW-1:0] TLAST = TIMEOUT_EN ? TW'(ENTRY_TIMEOUT - 1) : '0;
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_NIBBLES - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t        state_q  = COLLECT;
  state_t        state_d;
  logic [WW-1:0] word_q   = '0;
  logic [WW-1:0] word_d;
  logic [2:0]    digits_q = '0;
  logic [2:0]    digits_d;
  logic [TW-1:0] timer_q  = '0;
  logic [TW-1:0] timer_d;
  logic          valid_q  = 1'b0;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= COLLECT;
      word_q   <= '0;
      digits_q <= '0;
      timer_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      digits_q <= digits_d;
      timer_q  <= timer_d;
      valid_q  <= (state_d == HOLD);
    end
  end

  // Clear beats everything; a clear coinciding with Ready in HOLD yields the
  // same post-transfer state, so it needs no separate branch.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    digits_d = digits_q;
    timer_d  = timer_q;
    if (KeyClear) begin
      state_d  = COLLECT;
      word_d   = '0;
      digits_d = '0;
      timer_d  = '0;
    end else if (state_q == HOLD) begin
      if (Ready) begin
        state_d  = COLLECT;
        word_d   = '0;
        digits_d = '0;
        timer_d  = '0;
      end
    end else if (KeyLoad) begin
      word_d   = (word_q << 4) | WW'(Nibble);
      digits_d = digits_q + 3'd1;
      timer_d  = '0;
      if (digits_q == LAST_DIGIT) state_d = HOLD;
    end else if (digits_q == '0) begin
      timer_d = '0;
    end else if (TIMEOUT_EN && (timer_q == TLAST)) begin
      word_d   = '0;
      digits_d = '0;
      timer_d  = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + TW'(1);
    end
  end

  assign Word   = word_q;
  assign Digits = digits_q;
  assign Valid  = valid_q;
endmodule

// File: tb/tb_nibble_word_loader.sv
// Bench for nibble_word_loader: queue-based entry model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_nibble_word_loader;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 10;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          KeyLoad = 1'b0;
  logic          KeyClear = 1'b0;
  logic [3:0]    Nibble = '0;
  logic          Ready = 1'b0;
  logic [4*N-1:0] Word;
  logic [2:0]    Digits;
  logic          Valid;

  nibble_word_loader #(.NUM_NIBBLES(N), .ENTRY_TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .KeyLoad(KeyLoad), .KeyClear(KeyClear),
    .Nibble(Nibble), .Word(Word), .Digits(Digits), .Valid(Valid), .Ready(Ready)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the entry is just the list of nibbles typed so far.
  int unsigned q[$];
  bit          held = 0;
  int          idle = 0;
  int          transfers = 0;

  function automatic logic [31:0] m_word();
    logic [31:0] w = 0;
    foreach (q[i]) w = ((w << 4) | q[i]) & 32'hFFFF;
    return w;
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      q.delete(); held = 0; idle = 0;
    end else if (KeyClear) begin
      if (held && Ready) transfers++;
      q.delete(); held = 0; idle = 0;
    end else if (held) begin
      if (Ready) begin transfers++; q.delete(); held = 0; end
    end else if (KeyLoad) begin
      q.push_back(int'(Nibble)); idle = 0;
      if (q.size() == N) held = 1;
    end else if (q.size() > 0) begin
      idle++;
      if (idle == TO) begin q.delete(); idle = 0; end
    end
  end

  logic [4*N-1:0] prev_word = '0;
  logic           prev_valid = 1'b0;

  always @(negedge Clock) begin
    chk("word", 32'(Word), m_word());
    chk("digits", 32'(Digits), 32'(q.size()));
    chk("valid", 32'(Valid), 32'(held));
    if (prev_valid && Valid) chk("hold_stable", 32'(Word), 32'(prev_word));
    prev_word  = Word;
    prev_valid = Valid;
  end

  // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic cyc(input bit rst, input bit kl, input bit kc, input logic [3:0] nib, input bit rdy);
    Reset = rst; KeyLoad = kl; KeyClear = kc; Nibble = nib; Ready = rdy;
    @(posedge Clock); #1;
    Reset = 1'b0; KeyLoad = 1'b0; KeyClear = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [31:0] w, input logic [31:0] d, input logic [31:0] v);
    chk({nm, "_word"}, 32'(Word), w);
    chk({nm, "_digits"}, 32'(Digits), d);
    chk({nm, "_valid"}, 32'(Valid), v);
    chk({nm, "_model"}, m_word(), w);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    lit("reset", 0, 0, 0);

    // Full entry, long hold, then handshake
    cyc(0, 1, 0, 4'h1, 0); cyc(0, 1, 0, 4'h2, 0); cyc(0, 1, 0, 4'h3, 0);
    cyc(0, 1, 0, 4'h4, 0);
    lit("load4", 32'h1234, 4, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
    lit("hold20", 32'h1234, 4, 1);
    cyc(0, 0, 0, 0, 1);
    lit("xfer", 0, 0, 0);
    chk("xfer_count", 32'(transfers), 1);

    // Clear wins over a simultaneous load
    cyc(0, 1, 0, 4'hA, 0); cyc(0, 1, 0, 4'hB, 0);
    cyc(0, 1, 1, 4'hC, 0);
    lit("clr_load", 0, 0, 0);
    cyc(0, 1, 0, 4'h5, 1);
    lit("after_clr", 32'h0005, 1, 0);
    cyc(0, 0, 1, 0, 0);

    // Loads ignored in HOLD
    cyc(0, 1, 0, 4'hB, 0); cyc(0, 1, 0, 4'hE, 0); cyc(0, 1, 0, 4'hE, 0);
    cyc(0, 1, 0, 4'hF, 0);
    cyc(0, 1, 0, 4'h7, 0);
    lit("hold_load", 32'hBEEF, 4, 1);
    cyc(0, 0, 0, 0, 1);
    chk("xfer_count2", 32'(transfers), 2);

    // Timeout discard and last-cycle rescue
    cyc(0, 1, 0, 4'h9, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
    lit("idle9", 32'h9, 1, 0);
    cyc(0, 0, 0, 0, 0);
    lit("timeout", 0, 0, 0);
    cyc(0, 1, 0, 4'h9, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 4'h8, 0);
    lit("rescue", 32'h98, 2, 0);
    cyc(0, 0, 1, 0, 0);

    // Reset overrides a handshake
    cyc(0, 1, 0, 4'h1, 0); cyc(0, 1, 0, 4'h2, 0); cyc(0, 1, 0, 4'h3, 0);
    cyc(0, 1, 0, 4'h4, 0);
    cyc(1, 0, 0, 0, 1);
    lit("rst_hold", 0, 0, 0);
    chk("rst_no_xfer", 32'(transfers), 2);

    // Clear with Ready in HOLD counts as a transfer
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 4'(i + 6), 0);
    lit("hold2", 32'h6789, 4, 1);
    cyc(0, 0, 1, 0, 1);
    lit("clr_rdy", 0, 0, 0);
    chk("clr_rdy_xfer", 32'(transfers), 3);

    // Ready in COLLECT has no effect
    cyc(0, 1, 0, 4'h3, 1);
    cyc(0, 0, 0, 0, 1);
    lit("rdy_collect", 32'h3, 1, 0);
    cyc(0, 0, 1, 0, 0);

    // Randomized traffic, alternating fast and slow typing phases
    for (int i = 0; i < 3000; i++) begin
      bit slow = ((i / 200) % 2) == 1;
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, slow ? 12 : 2) == 0,
          $urandom_range(0, 39) == 0,
          4'($urandom_range(0, 15)),
          $urandom_range(0, 5) == 0);
    end

    @(negedge Clock); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
